dds_engine: RTL

- Parametrised, single-clock successor to the DDS top level. Replaces the divided-clock scheme with an internal sample-tick clock enable.
- Adds double-buffered tuning, phase offset, phase clear, extended waveform modes, programmable pulse duty, amplitude scaling and a registered output with a valid strobe.
- Sits between the register/IO front end and the DAC output pins.

---
 rtl/dds_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dds_engine.sv
// Single-clock direct digital synthesiser: tick-enabled phase accumulator with
// double-buffered tuning, waveform shaping, amplitude scaling and a valid strobe.
`timescale 1ns/1ps

module dds_engine #(
  parameter int ACC_W  = 16,
  parameter int PH_W   = 14,
  parameter int OUT_W  = 12,
  parameter int TUNE_W = 16,
  parameter int DIV    = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TUNE_W-1:0] tune_in,
  input  logic              tune_load,
  input  logic [PH_W-1:0]   phase_off,
  input  logic              phase_clr,
  input  logic [2:0]        mode,
  input  logic [7:0]        duty,
  input  logic [3:0]        amp,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid
);

  localparam int               CNT_W      = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [OUT_W-1:0] MID        = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [15:0]      LFSR_SEED  = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS  = 16'hB400;

  localparam logic [2:0] MODE_SAW   = 3'd0;
  localparam logic [2:0] MODE_RAMP  = 3'd1;
  localparam logic [2:0] MODE_TRI   = 3'd2;
  localparam logic [2:0] MODE_PULSE = 3'd3;
  localparam logic [2:0] MODE_NOISE = 3'd4;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TUNE_W-1:0] tune_act_q, tune_act_d;
  logic [TUNE_W-1:0] tune_shd_q, tune_shd_d;
  logic              load_pend_q, load_pend_d;
  logic              clr_pend_q, clr_pend_d;
  logic [2:0]        mode_q, mode_d;
  logic [7:0]        duty_q, duty_d;
  logic [3:0]        amp_q, amp_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              ph1_q, ph2_q;
  logic [OUT_W-1:0]  w_q, w_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_valid_q;

  logic              tick;
  logic [PH_W-1:0]   p;
  logic [OUT_W-1:0]  tri_t;
  logic signed [OUT_W:0]   s;
  logic signed [5:0]       gain;
  logic signed [OUT_W+6:0] prod;

  assign tick = (cnt_q == CNT_LAST);

  // Tick-domain control: divider, double-buffered tuning, clear request, sampled controls.
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    tune_shd_d  = tune_load ? tune_in : tune_shd_q;
    tune_act_d  = (tick && load_pend_q) ? tune_shd_q : tune_act_q;
    load_pend_d = tune_load ? 1'b1 : (tick ? 1'b0 : load_pend_q);
    clr_pend_d  = phase_clr ? 1'b1 : (tick ? 1'b0 : clr_pend_q);
    acc_d       = acc_q;
    mode_d      = mode_q;
    duty_d      = duty_q;
    amp_d       = amp_q;
    lfsr_d      = lfsr_q;
    if (tick) begin
      acc_d  = clr_pend_q ? '0 : acc_q + ACC_W'(tune_act_q);
      mode_d = mode;
      duty_d = duty;
      amp_d  = amp;
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // NOTE: every output of an always_comb gets a default before any branch,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    p     = acc_q[ACC_W-1 -: PH_W] + phase_off;
    tri_t = p[PH_W-2 -: OUT_W];
    w_d   = MID;
    case (mode_q)
      MODE_SAW:   w_d = p[PH_W-1 -: OUT_W];
      MODE_RAMP:  w_d = ~p[PH_W-1 -: OUT_W];
      MODE_TRI:   w_d = p[PH_W-1] ? ~tri_t : tri_t;
      MODE_PULSE: w_d = (p[PH_W-1 -: 8] < duty_q) ? '1 : '0;
      MODE_NOISE: w_d = lfsr_q[15 -: OUT_W];
      default:    w_d = MID;
    endcase
  end

  // Gain (amp+1)/16 applied around midscale; the arithmetic shift floors.
  always_comb begin
    s     = $signed({1'b0, w_q}) - $signed({1'b0, MID});
    gain  = $signed({2'b00, amp_q}) + 6'sd1;
    prod  = (OUT_W+7)'(s) * (OUT_W+7)'(gain);
    out_d = MID + OUT_W'(prod >>> 4);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      tune_act_q  <= '0;
      tune_shd_q  <= '0;
      load_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      mode_q      <= MODE_SAW;
      duty_q      <= '0;
      amp_q       <= 4'd15;
      lfsr_q      <= LFSR_SEED;
      ph1_q       <= 1'b0;
      ph2_q       <= 1'b0;
      w_q         <= MID;
      out_q       <= MID;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      tune_act_q  <= tune_act_d;
      tune_shd_q  <= tune_shd_d;
      load_pend_q <= load_pend_d;
      clr_pend_q  <= clr_pend_d;
      mode_q      <= mode_d;
      duty_q      <= duty_d;
      amp_q       <= amp_d;
      lfsr_q      <= lfsr_d;
      ph1_q       <= tick;
      ph2_q       <= ph1_q;
      out_valid_q <= ph2_q;
      if (ph1_q) w_q   <= w_d;
      if (ph2_q) out_q <= out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
